// File: rtl/jtag_full_adder_top.sv
// Full adder behind a 1149.1-style TAP with IR, BYPASS, optional IDCODE and a 5-cell BSR.
// Define IDCODE_EN to include the 32-bit IDCODE register (reset instruction IDCODE, else BYPASS).
module jtag_full_adder_top (
  input  logic tck,
  input  logic trst,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

`ifdef IDCODE_EN
  localparam logic [3:0] RESET_IR = 4'b0001;
`else
  localparam logic [3:0] RESET_IR = 4'b1111;
`endif

  tap_state_t  state;
  logic [3:0]  ir_shift;
  logic [3:0]  ir_active;
  logic        bypass_sr;
  logic [4:0]  bsr_shift;
  logic [4:0]  bsr_upd;
  logic        sel_idcode;
  logic        sel_bsr;
  logic        is_extest;
  logic        is_intest;
  logic        ia, ib, ic;
  logic        core_sum, core_carry;
  logic        dr_lsb;
  logic        tdo_next;

`ifdef IDCODE_EN
  logic [31:0] idcode_sr;
  assign sel_idcode = (ir_active == 4'b0001);
`else
  assign sel_idcode = 1'b0;
`endif

  assign is_extest = (ir_active == 4'b0011);
  assign is_intest = (ir_active == 4'b0100);
  assign sel_bsr   = (ir_active == 4'b0010) || is_extest || is_intest;

  // Core inputs come from the a/b/c update latches only under INTEST.
  assign ia = is_intest ? bsr_upd[0] : a;
  assign ib = is_intest ? bsr_upd[1] : b;
  assign ic = is_intest ? bsr_upd[2] : c;
  assign core_sum   = ia ^ ib ^ ic;
  assign core_carry = (ia & ib) | (ia & ic) | (ib & ic);
  assign sum   = is_extest ? bsr_upd[3] : core_sum;
  assign carry = is_extest ? bsr_upd[4] : core_carry;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state <= TLR;
    end else begin
      case (state)
        TLR:     state <= tms ? TLR    : RTI;
        RTI:     state <= tms ? SEL_DR : RTI;
        SEL_DR:  state <= tms ? SEL_IR : CAP_DR;
        CAP_DR:  state <= tms ? EX1_DR : SH_DR;
        SH_DR:   state <= tms ? EX1_DR : SH_DR;
        EX1_DR:  state <= tms ? UPD_DR : PAU_DR;
        PAU_DR:  state <= tms ? EX2_DR : PAU_DR;
        EX2_DR:  state <= tms ? UPD_DR : SH_DR;
        UPD_DR:  state <= tms ? SEL_DR : RTI;
        SEL_IR:  state <= tms ? TLR    : CAP_IR;
        CAP_IR:  state <= tms ? EX1_IR : SH_IR;
        SH_IR:   state <= tms ? EX1_IR : SH_IR;
        EX1_IR:  state <= tms ? UPD_IR : PAU_IR;
        PAU_IR:  state <= tms ? EX2_IR : PAU_IR;
        EX2_IR:  state <= tms ? UPD_IR : SH_IR;
        UPD_IR:  state <= tms ? SEL_DR : RTI;
        default: state <= TLR;
      endcase
    end
  end

  // Capture and shift stages; these keep their contents through Test-Logic-Reset.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift  <= 4'b0000;
      bypass_sr <= 1'b0;
      bsr_shift <= 5'b00000;
`ifdef IDCODE_EN
      idcode_sr <= 32'h0;
`endif
    end else begin
      if (state == CAP_IR) ir_shift <= 4'b0001;
      else if (state == SH_IR) ir_shift <= {tdi, ir_shift[3:1]};

      if (state == CAP_DR) begin
        if (sel_bsr) bsr_shift <= {core_carry, core_sum, c, b, a};
`ifdef IDCODE_EN
        else if (sel_idcode) idcode_sr <= 32'hDEADBEEF;
`endif
        else bypass_sr <= 1'b0;
      end else if (state == SH_DR) begin
        if (sel_bsr) bsr_shift <= {tdi, bsr_shift[4:1]};
`ifdef IDCODE_EN
        else if (sel_idcode) idcode_sr <= {tdi, idcode_sr[31:1]};
`endif
        else bypass_sr <= tdi;
      end
    end
  end

  always_comb begin
    dr_lsb = bypass_sr;
    if (sel_bsr) dr_lsb = bsr_shift[0];
`ifdef IDCODE_EN
    else if (sel_idcode) dr_lsb = idcode_sr[0];
`endif
    tdo_next = 1'b0;
    if (state == SH_IR) tdo_next = ir_shift[0];
    else if (state == SH_DR) tdo_next = dr_lsb;
  end

  // Falling-edge side: tdo launch and the update latches.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir_active <= RESET_IR;
      bsr_upd   <= 5'b00000;
      tdo       <= 1'b0;
    end else begin
      tdo <= tdo_next;
      if (state == TLR) begin
        ir_active <= RESET_IR;
        bsr_upd   <= 5'b00000;
      end else begin
        if (state == UPD_IR) ir_active <= ir_shift;
        if (state == UPD_DR && sel_bsr) bsr_upd <= bsr_shift;
      end
    end
  end

endmodule

// File: tb/tb_jtag_full_adder_top.sv
// Directed bench for jtag_full_adder_top: TAP driven through tck/tms/tdi, tdo sampled after falling tck.
module tb_jtag_full_adder_top;

  logic tck = 1'b0;
  logic trst, tms, tdi, tdo;
  logic a, b, c, sum, carry;
  int   checks = 0;
  int   fails  = 0;

  jtag_full_adder_top dut (
    .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo),
    .a(a), .b(b), .c(c), .sum(sum), .carry(carry)
  );

  always #10 tck = ~tck;

  // Every task starts and ends 1 time unit after a falling tck edge.
  task automatic cycle();
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic step(input logic tms_v);
    tms = tms_v;
    tdi = 1'b0;
    cycle();
  endtask

  // Shift n bits from Shift-xR, then Exit1 -> Update -> Run-Test/Idle.
  task automatic shift_bits(input int n, input logic [31:0] din, output logic [31:0] dout);
    dout = 32'h0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tms = (i == n - 1);
      tdi = din[i];
      cycle();
    end
    step(1'b1);
    step(1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code, output logic [31:0] cap);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    shift_bits(4, {28'h0, code}, cap);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    step(1'b1); step(1'b0); step(1'b0);
    shift_bits(n, din, dout);
  endtask

  task automatic test_reset();
    trst = 1'b0; tms = 1'b1; tdi = 1'b0;
    a = 1'b1; b = 1'b0; c = 1'b0;
    #25;
    checks++;
    if (tdo !== 1'b0) begin fails++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    checks++;
    if ({carry, sum} !== 2'b01) begin fails++; $display("FAIL reset_func_100: got %b expected 01", {carry, sum}); end
    a = 1'b1; b = 1'b1; c = 1'b1; #1;
    checks++;
    if ({carry, sum} !== 2'b11) begin fails++; $display("FAIL reset_func_111: got %b expected 11", {carry, sum}); end
    a = 1'b0; b = 1'b1; c = 1'b1; #1;
    checks++;
    if ({carry, sum} !== 2'b10) begin fails++; $display("FAIL reset_func_011: got %b expected 10", {carry, sum}); end
    @(negedge tck); #1;
    trst = 1'b1;
    step(1'b1);
    step(1'b0);
  endtask

  // Checks the DR selected by the reset instruction from Run-Test/Idle.
  task automatic check_reset_dr(input string name);
    logic [31:0] dout;
`ifdef IDCODE_EN
    scan_dr(32, 32'h0, dout);
    checks++;
    if (dout !== 32'hDEADBEEF) begin fails++; $display("FAIL %s_idcode: got %h expected deadbeef", name, dout); end
`else
    scan_dr(8, 32'h0000_00B2, dout);
    checks++;
    if (dout[7:0] !== 8'h64) begin fails++; $display("FAIL %s_bypass: got %h expected 64", name, dout[7:0]); end
`endif
  endtask

  task automatic test_idcode();
    check_reset_dr("after_reset");
  endtask

  task automatic test_ir_capture();
    logic [31:0] cap;
    load_ir(4'b0010, cap);
    checks++;
    if (cap[3:0] !== 4'b0001) begin fails++; $display("FAIL ir_capture: got %b expected 0001", cap[3:0]); end
  endtask

  task automatic test_sample();
    logic [31:0] dout;
    a = 1'b1; b = 1'b1; c = 1'b0;
    scan_dr(5, 32'h0, dout);
    checks++;
    if (dout[4:0] !== 5'b10011) begin fails++; $display("FAIL sample_capture: got %b expected 10011", dout[4:0]); end
  endtask

  task automatic test_extest();
    logic [31:0] dout, cap;
    load_ir(4'b0010, cap);
    scan_dr(5, 32'h08, dout);
    load_ir(4'b0011, cap);
    a = 1'b1; b = 1'b1; c = 1'b1; #1;
    checks++;
    if ({carry, sum} !== 2'b01) begin fails++; $display("FAIL extest_pins_111: got %b expected 01", {carry, sum}); end
    a = 1'b0; b = 1'b0; c = 1'b0; #1;
    checks++;
    if ({carry, sum} !== 2'b01) begin fails++; $display("FAIL extest_pins_000: got %b expected 01", {carry, sum}); end
    a = 1'b1; b = 1'b0; c = 1'b1;
    scan_dr(5, 32'h08, dout);
    checks++;
    if (dout[4:0] !== 5'b10101) begin fails++; $display("FAIL extest_capture: got %b expected 10101", dout[4:0]); end
    checks++;
    if ({carry, sum} !== 2'b01) begin fails++; $display("FAIL extest_pins_hold: got %b expected 01", {carry, sum}); end
  endtask

  task automatic test_intest();
    logic [31:0] dout, cap;
    load_ir(4'b0010, cap);
    scan_dr(5, 32'h05, dout);
    load_ir(4'b0100, cap);
    a = 1'b0; b = 1'b0; c = 1'b0; #1;
    checks++;
    if ({carry, sum} !== 2'b10) begin fails++; $display("FAIL intest_pins: got %b expected 10", {carry, sum}); end
    scan_dr(5, 32'h05, dout);
    checks++;
    if (dout[4:0] !== 5'b10000) begin fails++; $display("FAIL intest_capture: got %b expected 10000", dout[4:0]); end
  endtask

  task automatic test_bypass();
    logic [31:0] dout, cap;
    load_ir(4'b1111, cap);
    scan_dr(4, 32'h5, dout);
    checks++;
    if (dout[3:0] !== 4'b1010) begin fails++; $display("FAIL bypass_delay: got %b expected 1010", dout[3:0]); end
  endtask

  task automatic test_tlr_tms();
    logic [31:0] dout, cap;
    load_ir(4'b0010, cap);
    scan_dr(5, 32'h08, dout);
    load_ir(4'b0011, cap);
    a = 1'b0; b = 1'b0; c = 1'b0; #1;
    checks++;
    if ({carry, sum} !== 2'b01) begin fails++; $display("FAIL tlr_pre_extest: got %b expected 01", {carry, sum}); end
    for (int i = 0; i < 5; i++) step(1'b1);
    checks++;
    if ({carry, sum} !== 2'b00) begin fails++; $display("FAIL tlr_functional: got %b expected 00", {carry, sum}); end
    step(1'b0);
    check_reset_dr("after_tlr");
  endtask

  task automatic test_trst_mid_shift();
    logic [31:0] dout, cap;
    load_ir(4'b0010, cap);
    scan_dr(5, 32'h08, dout);
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    tms = 1'b0; tdi = 1'b1; cycle();
    tdi = 1'b1; cycle();
    trst = 1'b0; #2;
    checks++;
    if (tdo !== 1'b0) begin fails++; $display("FAIL trst_tdo: got %b expected 0", tdo); end
    trst = 1'b1;
    a = 1'b1; b = 1'b1; c = 1'b1; #1;
    checks++;
    if ({carry, sum} !== 2'b11) begin fails++; $display("FAIL trst_functional: got %b expected 11", {carry, sum}); end
    step(1'b0);
    check_reset_dr("after_trst");
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_capture();
    test_sample();
    test_extest();
    test_intest();
    test_bypass();
    test_tlr_tms();
    test_trst_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
